// File: rtl/linebuf_pp.sv
// linebuf_pp: ping-pong scanline buffer for sprite compositing.
// The sprite engine writes bank wbank while scan-out reads bank ~wbank.
// After reset, both banks are cleared to TRANS one location per cycle.
// Read-out can clear locations behind itself. Writes skip transparent pixels.
// With PRI=1, the first opaque pixel written to a location wins (read-modify-write).
// Memory updates from the clear port and the pixel port are forwarded to both
// read points (scan-out and the PRI=1 compare), so every operation behaves as if
// it were applied in issue order.
// Interface timing: there is no handshake. Every input is sampled at each rising
// edge while busy=0 and ignored while busy=1. rdat is valid one cycle after radr.
module linebuf_pp #(
  parameter int            AW    = 9,
  parameter int            DW    = 11,
  parameter logic [DW-1:0] TRANS = '0,
  parameter bit            PRI   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap,
  output logic          busy,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] radr,
  input  logic          rclr,
  output logic [DW-1:0] rdat,
  output logic          wbank
);

  localparam int DEPTH = 2 ** (AW + 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;          // {bank, addr} sweep during CLEAR
  logic          wbank_q, wbank_d;
  logic [DW-1:0] rdat_q, rdat_d;

  // Read-side clear, tagged with {bank, addr}; lands one cycle after the read
  logic          clr_v_q, clr_v_d;
  logic [AW:0]   clr_a_q, clr_a_d;

  // PRI=1 stage-1 register: tagged write plus the content seen at issue time
  logic          s1_v_q, s1_v_d;
  logic [AW:0]   s1_a_q, s1_a_d;
  logic [DW-1:0] s1_dat_q, s1_dat_d;
  logic [DW-1:0] s1_cur_q, s1_cur_d;

  // Pixel commit landing in memory at the coming edge
  logic          cm_en;
  logic [AW:0]   cm_a;
  logic [DW-1:0] cm_dat;

  logic [AW:0]   rd_a, wr_a;
  logic [DW-1:0] mem_q [DEPTH];

  // Value location a will hold after this edge; a pixel commit beats a clear
  function automatic logic [DW-1:0] fwd(
    input logic [AW:0]   a,
    input logic [DW-1:0] m,
    input logic          c_en,
    input logic [AW:0]   c_a,
    input logic [DW-1:0] c_dat,
    input logic          k_en,
    input logic [AW:0]   k_a
  );
    if (c_en && (c_a == a)) return c_dat;
    if (k_en && (k_a == a)) return TRANS;
    return m;
  endfunction

  assign rd_a  = {~wbank_q, radr};
  assign wr_a  = {wbank_q, wadr};
  assign busy  = (state_q == ST_CLEAR);
  assign rdat  = rdat_q;
  assign wbank = wbank_q;

  // Select the pixel commit: direct write (PRI=0) or stage-2 conditional (PRI=1)
  always_comb begin
    cm_en  = 1'b0;
    cm_a   = s1_a_q;
    cm_dat = s1_dat_q;
    if (PRI) begin
      cm_en = s1_v_q && (s1_cur_q == TRANS);
    end else begin
      cm_en  = (state_q == ST_RUN) && we && (wdat != TRANS);
      cm_a   = wr_a;
      cm_dat = wdat;
    end
  end

  // FSM next state, bank toggle, read path and write-pipeline capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wbank_d  = wbank_q;
    rdat_d   = rdat_q;
    clr_v_d  = 1'b0;
    clr_a_d  = clr_a_q;
    s1_v_d   = 1'b0;
    s1_a_d   = s1_a_q;
    s1_dat_d = s1_dat_q;
    s1_cur_d = s1_cur_q;
    case (state_q)
      ST_CLEAR: begin
        rdat_d = TRANS;
        cnt_d  = cnt_q + (AW + 1)'(1);
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: begin
        if (swap) wbank_d = ~wbank_q;
        rdat_d  = fwd(rd_a, mem_q[rd_a], cm_en, cm_a, cm_dat, clr_v_q, clr_a_q);
        clr_v_d = rclr;
        clr_a_d = rd_a;
        if (PRI && we && (wdat != TRANS)) begin
          s1_v_d   = 1'b1;
          s1_a_d   = wr_a;
          s1_dat_d = wdat;
          s1_cur_d = fwd(wr_a, mem_q[wr_a], cm_en, cm_a, cm_dat, clr_v_q, clr_a_q);
        end
      end
    endcase
  end

  // Control and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      wbank_q  <= 1'b0;
      rdat_q   <= TRANS;
      clr_v_q  <= 1'b0;
      clr_a_q  <= '0;
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_dat_q <= TRANS;
      s1_cur_q <= TRANS;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wbank_q  <= wbank_d;
      rdat_q   <= rdat_d;
      clr_v_q  <= clr_v_d;
      clr_a_q  <= clr_a_d;
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_dat_q <= s1_dat_d;
      s1_cur_q <= s1_cur_d;
    end
  end

  // Memory array: sweep clear, read-side clear, then pixel commit (commit wins)
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= TRANS;
      end else begin
        if (clr_v_q) mem_q[clr_a_q] <= TRANS;
        if (cm_en) mem_q[cm_a] <= cm_dat;
      end
    end
  end

endmodule

// File: tb/tb_linebuf_pp.sv
// tb_linebuf_pp: drives one PRI=0 and one PRI=1 instance (AW=4) with shared
// stimulus. Expected outputs come from a sequential array model of both banks.
module tb_linebuf_pp;

  localparam int AW = 4;
  localparam int DW = 11;
  localparam int N  = 16;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          swap  = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] wadr  = '0;
  logic [DW-1:0] wdat  = '0;
  logic [AW-1:0] radr  = '0;
  logic          rclr  = 1'b0;

  logic          busy0, busy1, wb0, wb1;
  logic [DW-1:0] rdat0, rdat1;

  always #5 clk = ~clk;

  linebuf_pp #(.AW(AW), .DW(DW), .TRANS('0), .PRI(1'b0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .swap(swap), .busy(busy0), .we(we), .wadr(wadr),
    .wdat(wdat), .radr(radr), .rclr(rclr), .rdat(rdat0), .wbank(wb0)
  );

  linebuf_pp #(.AW(AW), .DW(DW), .TRANS('0), .PRI(1'b1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .swap(swap), .busy(busy1), .we(we), .wadr(wadr),
    .wdat(wdat), .radr(radr), .rclr(rclr), .rdat(rdat1), .wbank(wb1)
  );

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m0 [2*N];
  logic [DW-1:0] m1 [2*N];
  int            wb_m     = 0;
  int            clr_left = 0;
  logic [DW-1:0] exp_rd0  = '0;
  logic [DW-1:0] exp_rd1  = '0;
  bit            started  = 1'b0;
  int            bcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge of inputs in issue order: read, read-clear, write, swap
  task automatic model_step();
    int ri;
    int wi;
    if (!rst_n) begin
      started  = 1'b1;
      clr_left = 2 * N;
      wb_m     = 0;
      exp_rd0  = '0;
      exp_rd1  = '0;
    end else if (started && clr_left > 0) begin
      clr_left--;
      exp_rd0 = '0;
      exp_rd1 = '0;
      if (clr_left == 0) begin
        for (int i = 0; i < 2 * N; i++) begin
          m0[i] = '0;
          m1[i] = '0;
        end
      end
    end else if (started) begin
      ri = (1 - wb_m) * N + int'(radr);
      wi = wb_m * N + int'(wadr);
      exp_rd0 = m0[ri];
      exp_rd1 = m1[ri];
      if (rclr) begin
        m0[ri] = '0;
        m1[ri] = '0;
      end
      if (we && wdat != '0) begin
        m0[wi] = wdat;
        if (m1[wi] == '0) m1[wi] = wdat;
      end
      if (swap) wb_m = 1 - wb_m;
    end
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare();
    if (!started) return;
    chk("busy_p0", busy0, (clr_left > 0) ? 1 : 0);
    chk("busy_p1", busy1, (clr_left > 0) ? 1 : 0);
    chk("wbank_p0", wb0, wb_m);
    chk("wbank_p1", wb1, wb_m);
    chk("rdat_p0", rdat0, exp_rd0);
    chk("rdat_p1", rdat1, exp_rd1);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    swap = 1'b0;
    we   = 1'b0;
    rclr = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    we   = 1'b1;
    wadr = AW'(a);
    wdat = DW'(d);
    tick();
    we   = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic rd(input int a, input bit clr);
    radr = AW'(a);
    rclr = clr;
    tick();
    rclr = 1'b0;
  endtask

  // ---------------- driver ----------------
  initial begin
    // Reset and clear-length measurement
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bcnt = busy0 ? 1 : 0;
    for (int i = 0; i < 200 && busy0; i++) begin
      tick();
      if (busy0) bcnt++;
    end
    chk("busy_len", bcnt, 32);

    // Both banks read back as transparent after the clear
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < N; a++) begin
        rd(a, 1'b0);
        chk("clr_rd_p0", rdat0, 0);
        chk("clr_rd_p1", rdat1, 0);
      end
      if (b == 0) do_swap();
    end

    // Last-wins vs first-wins, and a dropped transparent write
    wr(5, 'h123);
    wr(5, 'h456);
    wr(6, 'h000);
    do_swap();
    rd(5, 1'b0);
    chk("lastwins_p0", rdat0, 'h456);
    chk("firstwins_p1", rdat1, 'h123);
    rd(6, 1'b0);
    chk("transwr_p0", rdat0, 0);

    // Back-to-back same-address writes under PRI=1
    wr(7, 'h0AA);
    wr(7, 'h0BB);
    do_swap();
    rd(7, 1'b0);
    chk("b2b_p1", rdat1, 'h0AA);
    chk("b2b_p0", rdat0, 'h0BB);

    // Write issued in the swap cycle lands in the pre-swap bank
    we = 1'b1; wadr = 4'd7; wdat = 11'h0CC; swap = 1'b1;
    tick();
    idle();
    rd(7, 1'b0);
    chk("swapwr_p1", rdat1, 'h0CC);
    chk("swapwr_p0", rdat0, 'h0CC);
    do_swap();
    rd(7, 1'b0);
    chk("untouched_p1", rdat1, 'h0AA);
    chk("untouched_p0", rdat0, 'h0BB);

    // Read with clear, then re-read
    wr(3, 'h155);
    do_swap();
    rd(3, 1'b1);
    chk("rclr_first", rdat0, 'h155);
    rd(4, 1'b0);
    rd(3, 1'b0);
    chk("rclr_second", rdat0, 0);
    chk("rclr_second_p1", rdat1, 0);
    wr(3, 'h155);
    do_swap();
    rd(3, 1'b0);
    chk("noclr_first", rdat0, 'h155);
    rd(4, 1'b0);
    rd(3, 1'b0);
    chk("noclr_second", rdat1, 'h155);
    rd(3, 1'b1);
    chk("b2b_clr_first", rdat0, 'h155);
    rd(3, 1'b0);
    chk("b2b_clr_second", rdat0, 0);
    chk("b2b_clr_second_p1", rdat1, 0);

    // Reset in the middle of a line with writes in flight
    wr(9, 'h1AB);
    we = 1'b1; wadr = 4'd5; wdat = 11'h2CD;
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy0, 1);
    chk("midrst_wbank", wb1, 0);
    chk("midrst_rdat", rdat1, 0);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) tick();
    chk("midrst_done", busy1, 0);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        rd(3 + 2 * k, 1'b0);
        chk("midrst_rd_p0", rdat0, 0);
        chk("midrst_rd_p1", rdat1, 0);
      end
      do_swap();
    end

    // Randomized traffic with addresses biased to collide
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
      swap  = ($urandom_range(0, 15) == 0);
      we    = ($urandom_range(0, 2) != 0);
      wadr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N - 1));
      wdat  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 2047));
      radr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N - 1));
      rclr  = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 40; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
